// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ debounced requesters.
// Rising edges on req become pending bits; each grant drives a start pulse and waits out the busy handshake.
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   input  logic                      tx_busy,
   output logic                      tx_start,
   output logic [DATA_W-1:0]         tx_data,
   output logic [2:0]                grant_id,
   output logic [N_REQ-1:0]          pending,
   output logic [N_REQ-1:0]          overrun,
   output logic                      timeout_err,
   output logic                      done
);

   localparam int TIMER_W = $clog2(TIMEOUT) + 1;
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } state_t;

   state_t               state_reg, state_next;
   logic [N_REQ-1:0]     req_q_reg;
   logic [N_REQ-1:0]     pending_reg, pending_next;
   logic [N_REQ-1:0]     overrun_reg, overrun_next;
   logic [N_REQ-1:0]     rise;
   logic [N_REQ-1:0]     clr;
   logic [2:0]           ptr_reg, ptr_next;
   logic [2:0]           grant_idx;
   logic                 grant_valid;
   logic                 grant_fire;
   logic [TIMER_W-1:0]   timer_reg, timer_next;
   logic                 tx_start_reg, tx_start_next;
   logic                 done_reg, done_next;
   logic                 timeout_err_reg, timeout_err_next;
   logic [DATA_W-1:0]    tx_data_reg, tx_data_next;
   logic [2:0]           grant_id_reg, grant_id_next;
   logic [DATA_W-1:0]    byte_sel [N_REQ];

   assign rise = req & ~req_q_reg;

   // A rise in the same cycle as the grant re-arms the bit and is not an overrun.
   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign byte_sel[gi]     = req_data[gi*DATA_W +: DATA_W];
         assign clr[gi]          = grant_fire && (grant_idx == 3'(gi));
         assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
         assign overrun_next[gi] = overrun_reg[gi] | (rise[gi] & pending_reg[gi] & ~clr[gi]);
      end
   endgenerate

   // Scan from ptr upward with wrap; the closest pending index to ptr wins.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         for (int j = 0; j < N_REQ; j++) begin
            if ((int'(ptr_reg) + k == j) || (int'(ptr_reg) + k == j + N_REQ)) begin
               if (pending_reg[j]) begin
                  grant_valid = 1'b1;
                  grant_idx   = 3'(j);
               end
            end
         end
      end
   end

   always_comb begin
      state_next       = state_reg;
      ptr_next         = ptr_reg;
      timer_next       = timer_reg;
      tx_start_next    = 1'b0;
      done_next        = 1'b0;
      timeout_err_next = timeout_err_reg;
      tx_data_next     = tx_data_reg;
      grant_id_next    = grant_id_reg;
      grant_fire       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (grant_valid) begin
               grant_fire = 1'b1;
               for (int j = 0; j < N_REQ; j++) begin
                  if (grant_idx == 3'(j)) begin
                     tx_data_next = byte_sel[j];
                  end
               end
               grant_id_next = grant_idx;
               ptr_next      = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
               tx_start_next = 1'b1;
               state_next    = START;
            end
         end
         START: begin
            timer_next = '0;
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            // Busy wins over the timeout when both land on the last cycle.
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (timer_reg == TIMER_LAST) begin
               timeout_err_next = 1'b1;
               state_next       = IDLE;
            end else begin
               timer_next = timer_reg + TIMER_W'(1);
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         req_q_reg       <= '1;
         pending_reg     <= '0;
         overrun_reg     <= '0;
         ptr_reg         <= '0;
         timer_reg       <= '0;
         tx_start_reg    <= 1'b0;
         done_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
         tx_data_reg     <= '0;
         grant_id_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         req_q_reg       <= req;
         pending_reg     <= pending_next;
         overrun_reg     <= overrun_next;
         ptr_reg         <= ptr_next;
         timer_reg       <= timer_next;
         tx_start_reg    <= tx_start_next;
         done_reg        <= done_next;
         timeout_err_reg <= timeout_err_next;
         tx_data_reg     <= tx_data_next;
         grant_id_reg    <= grant_id_next;
      end
   end

   assign tx_start    = tx_start_reg;
   assign tx_data     = tx_data_reg;
   assign grant_id    = grant_id_reg;
   assign pending     = pending_reg;
   assign overrun     = overrun_reg;
   assign timeout_err = timeout_err_reg;
   assign done        = done_reg;

endmodule
